// File: rtl/rs_pkg.sv
// Shared Reed-Solomon GF(2^8) definitions: field constants,
// frame FSM states and a reference multiply.
package rs_pkg;

    localparam int SYM_W = 8;
    localparam logic [SYM_W:0] GF_POLY = 9'h11D;

    typedef logic [SYM_W-1:0] sym_t;

    typedef enum logic {
        IDLE,
        ACTIVE
    } fsm_e;

    // Shift-and-add multiply reduced by GF_POLY.
    function automatic sym_t gf_mul(input sym_t a, input sym_t b);
        sym_t p;
        sym_t x;
        p = '0;
        x = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) p = p ^ x;
            if (x[SYM_W-1]) x = (x << 1) ^ GF_POLY[SYM_W-1:0];
            else            x = x << 1;
        end
        return p;
    endfunction

endpackage

// File: rtl/rs_forney_correct_if.sv
// Beat-level handshake bundle for the Forney correction stage.
// out_err_cnt exists only when RS_FORNEY_ERRCNT_EN is defined.
interface rs_forney_correct_if
    import rs_pkg::*;
#(
    parameter int T = 8
);
    localparam int CW = $clog2(T + 1);

    logic          in_valid;
    logic          in_ready;
    logic          in_sop;
    logic          in_eop;
    sym_t          in_data;
    logic          in_root;
    sym_t          in_omega;
    sym_t          in_lambda_dv;
    logic [CW-1:0] in_lambda_deg;

    logic          out_valid;
    logic          out_ready;
    sym_t          out_data;
    logic          out_sop;
    logic          out_eop;
    logic          out_fail;
`ifdef RS_FORNEY_ERRCNT_EN
    logic [CW-1:0] out_err_cnt;
`endif

    modport master (
        output in_valid, in_sop, in_eop, in_data,
        output in_root, in_omega, in_lambda_dv,
        output in_lambda_deg, out_ready,
        input  in_ready, out_valid, out_data,
        input  out_sop, out_eop, out_fail
`ifdef RS_FORNEY_ERRCNT_EN
        , input out_err_cnt
`endif
    );

    modport slave (
        input  in_valid, in_sop, in_eop, in_data,
        input  in_root, in_omega, in_lambda_dv,
        input  in_lambda_deg, out_ready,
        output in_ready, out_valid, out_data,
        output out_sop, out_eop, out_fail
`ifdef RS_FORNEY_ERRCNT_EN
        , output out_err_cnt
`endif
    );

endinterface

// File: rtl/gf256_inv.sv
// Combinational GF(2^8) inverse; an input of zero yields zero.
module gf256_inv
    import rs_pkg::*;
(
    input  sym_t a_i,
    output sym_t inv_o
);
    sym_t sq;
    sym_t acc;

    // a^-1 = a^254 = product of a^(2^k) for k = 1..7
    always_comb begin
        sq  = a_i;
        acc = sym_t'(1);
        for (int k = 1; k < SYM_W; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
    end

    assign inv_o = acc;
endmodule

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier over the shared field polynomial.
module gf256_mul
    import rs_pkg::*;
(
    input  sym_t a_i,
    input  sym_t b_i,
    output sym_t p_o
);
    assign p_o = gf_mul(a_i, b_i);
endmodule

// File: rtl/rs_forney_correct.sv
// Forney error-value correction: two-stage pipeline plus frame FSM.
// Define RS_FORNEY_ERRCNT_EN to drive out_err_cnt on the eop beat.
module rs_forney_correct
    import rs_pkg::*;
#(
    parameter int T = 8
) (
    input  logic clk,
    input  logic rst,
    rs_forney_correct_if.slave bus
);
    localparam int CW = $clog2(T + 1);
    typedef logic [CW-1:0] cnt_t;

    fsm_e state_q, state_d;
    cnt_t cnt_q, cnt_d;
    cnt_t deg_q, deg_d;
    logic bad_q, bad_d;

    logic v1_q, r1_q, z1_q;
    logic sop1_q, eop1_q, fail1_q;
    sym_t d1_q, om1_q, inv1_q;

    logic v2_q, sop2_q, eop2_q, fail2_q;
    sym_t d2_q;

    logic adv, take, keep;
    logic bad_new, fail_new;
    cnt_t cnt_base, cnt_new, deg_eff;
    sym_t inv_w, prod_w, err_w;

    assign adv  = bus.out_ready | ~v2_q;
    assign take = bus.in_valid & adv;
    assign keep = bus.in_sop | (state_q == ACTIVE);

    assign bus.in_ready = adv;

    gf256_inv u_inv (
        .a_i   (bus.in_lambda_dv),
        .inv_o (inv_w)
    );

    gf256_mul u_mul (
        .a_i (om1_q),
        .b_i (inv1_q),
        .p_o (prod_w)
    );

    assign err_w = z1_q ? '0 : prod_w;

    // Root accounting for this beat; sop restarts the frame totals.
    always_comb begin
        cnt_base = bus.in_sop ? '0 : cnt_q;
        deg_eff  = bus.in_sop ? bus.in_lambda_deg : deg_q;
        cnt_new  = cnt_base;
        if (bus.in_root && (cnt_base != '1))
            cnt_new = cnt_base + cnt_t'(1);
        bad_new  = (~bus.in_sop & bad_q)
                 | (bus.in_root & (bus.in_lambda_dv == '0));
        fail_new = bus.in_eop & (bad_new | (cnt_new != deg_eff));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deg_d   = deg_q;
        bad_d   = bad_q;
        case (state_q)
            IDLE:    if (take && bus.in_sop)
                         state_d = bus.in_eop ? IDLE : ACTIVE;
            ACTIVE:  if (take && bus.in_eop)
                         state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (take && keep) begin
            cnt_d = cnt_new;
            deg_d = deg_eff;
            bad_d = bad_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            deg_q   <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            deg_q   <= deg_d;
            bad_q   <= bad_d;
        end
    end

    // Both stages advance together; a stall freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            r1_q    <= 1'b0;
            z1_q    <= 1'b0;
            sop1_q  <= 1'b0;
            eop1_q  <= 1'b0;
            fail1_q <= 1'b0;
            d1_q    <= '0;
            om1_q   <= '0;
            inv1_q  <= '0;
            v2_q    <= 1'b0;
            sop2_q  <= 1'b0;
            eop2_q  <= 1'b0;
            fail2_q <= 1'b0;
            d2_q    <= '0;
        end else if (adv) begin
            v1_q    <= take & keep;
            r1_q    <= bus.in_root;
            z1_q    <= (bus.in_lambda_dv == '0);
            sop1_q  <= bus.in_sop;
            eop1_q  <= bus.in_eop;
            fail1_q <= fail_new;
            d1_q    <= bus.in_data;
            om1_q   <= bus.in_omega;
            inv1_q  <= inv_w;
            v2_q    <= v1_q;
            sop2_q  <= sop1_q;
            eop2_q  <= eop1_q;
            fail2_q <= fail1_q;
            d2_q    <= r1_q ? (d1_q ^ err_w) : d1_q;
        end
    end

    assign bus.out_valid = v2_q;
    assign bus.out_data  = d2_q;
    assign bus.out_sop   = v2_q & sop2_q;
    assign bus.out_eop   = v2_q & eop2_q;
    assign bus.out_fail  = v2_q & eop2_q & fail2_q;

`ifdef RS_FORNEY_ERRCNT_EN
    cnt_t ec1_q, ec2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ec1_q <= '0;
            ec2_q <= '0;
        end else if (adv) begin
            ec1_q <= bus.in_eop ? cnt_new : '0;
            ec2_q <= ec1_q;
        end
    end

    assign bus.out_err_cnt = (v2_q & eop2_q) ? ec2_q : '0;
`endif

endmodule

// File: tb/tb_rs_forney_correct.sv
// Randomized bench for rs_forney_correct against a frame-level
// model built on GF(2^8) log/antilog tables.
module tb_rs_forney_correct;

    localparam int T    = 8;
    localparam int CW   = $clog2(T + 1);
    localparam int MAXC = (1 << CW) - 1;

    logic clk;
    logic rst;

    rs_forney_correct_if #(.T(T)) bus ();

    rs_forney_correct #(.T(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0]    d;
        logic          sop;
        logic          eop;
        logic          fail;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t        expq[$];
    logic [10:0] cap[$];
    logic [10:0] capa[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit stall_en = 0;

    int gexp[255];
    int glog[256];

    bit m_active;
    int m_roots;
    int m_deg;
    bit m_bad;

    int fr_d[256];
    int fr_om[256];
    int fr_dv[256];
    bit fr_root[256];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic void build_tables();
        int x;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = x << 1;
            if (x > 255) x = x ^ 'h11D;
        end
    endfunction

    function automatic int gf_div(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] - glog[b] + 255) % 255];
    endfunction

    function automatic void model_accept(input bit sop, input bit eop,
        input bit root, input int d, input int om, input int dv,
        input int deg);
        exp_t o;
        int   sat;
        if (!m_active && !sop) return;
        if (sop) begin
            m_roots = 0;
            m_deg   = deg;
            m_bad   = 0;
        end
        if (root) begin
            m_roots++;
            if (dv == 0) m_bad = 1;
        end
        sat    = (m_roots > MAXC) ? MAXC : m_roots;
        o.d    = root ? 8'(d ^ gf_div(om, dv)) : 8'(d);
        o.sop  = sop;
        o.eop  = eop;
        o.fail = eop && ((sat != m_deg) || m_bad);
        o.cnt  = eop ? CW'(sat) : '0;
        m_active = !eop;
        expq.push_back(o);
    endfunction

    task automatic drive(input bit sop, input bit eop, input bit root,
        input int d, input int om, input int dv, input int deg);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.in_valid      = 1'b1;
        bus.in_sop        = sop;
        bus.in_eop        = eop;
        bus.in_root       = root;
        bus.in_data       = 8'(d);
        bus.in_omega      = 8'(om);
        bus.in_lambda_dv  = 8'(dv);
        bus.in_lambda_deg = CW'(deg);
        #4;
        while (!bus.in_ready && guard < 1000) begin
            @(negedge clk);
            #4;
            guard++;
        end
        if (guard >= 1000) begin
            check("in_ready_timeout", 32'(bus.in_ready), 1);
            bus.in_valid = 1'b0;
        end else begin
            model_accept(sop, eop, root, d, om, dv, deg);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        idle();
        g = 0;
        while (expq.size() != 0 && g < 5000) begin
            @(posedge clk);
            g++;
        end
        check("drain", expq.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic build_frame(input int n, input int nroots);
        int p;
        for (int i = 0; i < n; i++) begin
            fr_d[i]    = $urandom_range(0, 255);
            fr_om[i]   = $urandom_range(0, 255);
            fr_dv[i]   = $urandom_range(0, 255);
            fr_root[i] = 0;
        end
        for (int k = 0; k < nroots && k < n; k++) begin
            do p = $urandom_range(0, n - 1); while (fr_root[p]);
            fr_root[p] = 1;
            fr_dv[p]   = $urandom_range(1, 255);
        end
    endtask

    task automatic send_frame(input int n, input int deg,
                              input bit with_eop);
        for (int i = 0; i < n; i++)
            drive(i == 0, with_eop && (i == n - 1), fr_root[i],
                  fr_d[i], fr_om[i], fr_dv[i],
                  (i == 0) ? deg : $urandom_range(0, MAXC));
    endtask

    // Output beat consumed at the coming rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst && bus.out_valid && bus.out_ready) begin
                check("out_expected", 32'(expq.size() != 0), 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    check("out_data", bus.out_data, e.d);
                    check("out_sop", bus.out_sop, e.sop);
                    check("out_eop", bus.out_eop, e.eop);
                    check("out_fail", bus.out_fail, e.fail);
`ifdef RS_FORNEY_ERRCNT_EN
                    check("out_err_cnt", bus.out_err_cnt, e.cnt);
`endif
                end
                cap.push_back({bus.out_sop, bus.out_eop,
                               bus.out_fail, bus.out_data});
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        int nr;
        int n;
        int deg;
        build_tables();
        m_active = 0;
        rst = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_sop        = 1'b0;
        bus.in_eop        = 1'b0;
        bus.in_root       = 1'b0;
        bus.in_data       = '0;
        bus.in_omega      = '0;
        bus.in_lambda_dv  = '0;
        bus.in_lambda_deg = '0;

        #12;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_out_sop", 32'(bus.out_sop), 0);
        check("rst_out_eop", 32'(bus.out_eop), 0);
        check("rst_out_fail", 32'(bus.out_fail), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // single-symbol frame, also checks two-edge latency
        drive(1, 1, 1, 'h55, 'h01, 'h02, 1);
        #1;
        check("lat1_valid", 32'(bus.out_valid), 0);
        idle();
        @(posedge clk);
        #1;
        check("lat2_valid", 32'(bus.out_valid), 1);
        check("lat2_data", 32'(bus.out_data), 32'('h55 ^ gf_div(1, 2)));
        check("lat2_sop_eop", 32'({bus.out_sop, bus.out_eop}), 3);
        check("lat2_fail", 32'(bus.out_fail), 0);
        drain();

        drive(1, 0, 1, 'h10, 'h03, 'h03, 1);
        drive(0, 1, 0, 'hAB, 'h00, 'h00, 0);
        drain();

        build_frame(255, 2);
        send_frame(255, 2, 1);
        drain();
        build_frame(255, 3);
        send_frame(255, 2, 1);
        drain();

        build_frame(255, 3);
        cap.delete();
        send_frame(255, 3, 1);
        drain();
        capa = cap;
        stall_en = 1;
        cap.delete();
        send_frame(255, 3, 1);
        drain();
        stall_en = 0;
        check("stall_len", cap.size(), capa.size());
        for (int i = 0; i < cap.size() && i < capa.size(); i++)
            check("stall_seq", 32'(cap[i]), 32'(capa[i]));

        // root count saturates at MAXC
        build_frame(30, 20);
        send_frame(30, MAXC, 1);
        drain();
        send_frame(30, MAXC - 1, 1);
        drain();

        // zero derivative: symbol passes through, frame fails
        drive(1, 0, 1, 'h21, 'h44, 'h00, 1);
        drive(0, 0, 0, 'h22, 'h00, 'h00, 0);
        drive(0, 1, 0, 'h23, 'h00, 'h00, 0);
        drain();

        // restart: abandoned frame then a full one
        build_frame(10, 2);
        send_frame(10, 2, 0);
        build_frame(5, 1);
        send_frame(5, 1, 1);
        drain();

        // reset mid-frame at symbol 100
        build_frame(200, 2);
        for (int i = 0; i < 100; i++)
            drive(i == 0, 0, fr_root[i], fr_d[i], fr_om[i],
                  fr_dv[i], 2);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        expq.delete();
        m_active = 0;
        #4;
        check("mid_rst_valid", 32'(bus.out_valid), 0);
        check("mid_rst_data", 32'(bus.out_data), 0);
        check("mid_rst_flags",
              32'({bus.out_sop, bus.out_eop, bus.out_fail}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 1, 'h77, 'h05, 'h09, 1);
        build_frame(40, 3);
        send_frame(40, 3, 1);
        drain();

        for (int f = 0; f < 8; f++) begin
            stall_en = f[0];
            n  = $urandom_range(1, 40);
            nr = $urandom_range(0, 6);
            deg = $urandom_range(0, 1) ? nr : $urandom_range(0, T);
            build_frame(n, nr);
            send_frame(n, deg, 1);
        end
        drain();
        stall_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
